// File: rtl/regfile_pkg.sv
// Shared constants and ecall state type for the multi-ported register file.
package regfile_pkg;

    localparam int unsigned DEFAULT_XLEN  = 64;
    localparam int unsigned DEFAULT_NREGS = 32;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_SP   = 2;
    localparam int unsigned REG_A0   = 10;
    localparam int unsigned REG_A7   = 17;
    localparam int unsigned NARGS    = 7;

    typedef enum logic [2:0] {
        ECALL_IDLE,
        ECALL_REQ,
        ECALL_WAIT,
        ECALL_WB,
        ECALL_DONE
    } ecall_state_e;

endpackage

// File: rtl/regfile_ecall_fsm.sv
// Environment-call handshake: snapshots a7/a0..a6, presents them to the
// responder, latches the result and requests a writeback to a0.
module regfile_ecall_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ecall_i,
    input  logic                  sys_ready_i,
    input  logic                  sys_resp_valid_i,
    input  logic [XLEN-1:0]       sys_resp_data_i,
    input  logic [XLEN-1:0]       snap_num_i,
    input  logic [NARGS*XLEN-1:0] snap_args_i,
    output logic                  sys_valid_o,
    output logic                  ecall_done_o,
    output logic [XLEN-1:0]       sys_num_o,
    output logic [NARGS*XLEN-1:0] sys_args_o,
    output logic                  wb_en_o,
    output logic [XLEN-1:0]       wb_data_o
);

    ecall_state_e          state_q, state_d;
    logic [XLEN-1:0]       num_q, num_d;
    logic [NARGS*XLEN-1:0] args_q, args_d;
    logic [XLEN-1:0]       res_q, res_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ECALL_IDLE;
            num_q   <= '0;
            args_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            args_q  <= args_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        args_d  = args_q;
        res_d   = res_q;
        case (state_q)
            ECALL_IDLE: begin
                if (ecall_i) begin
                    num_d   = snap_num_i;
                    args_d  = snap_args_i;
                    state_d = ECALL_REQ;
                end
            end
            ECALL_REQ:  if (sys_ready_i) state_d = ECALL_WAIT;
            ECALL_WAIT: begin
                if (sys_resp_valid_i) begin
                    res_d   = sys_resp_data_i;
                    state_d = ECALL_WB;
                end
            end
            // A dropped ecall still finishes through WB; DONE then exits at once.
            ECALL_WB:   state_d = ECALL_DONE;
            ECALL_DONE: if (!ecall_i) state_d = ECALL_IDLE;
            default:    state_d = ECALL_IDLE;
        endcase
    end

    assign sys_valid_o  = (state_q == ECALL_REQ);
    assign ecall_done_o = (state_q == ECALL_DONE);
    assign wb_en_o      = (state_q == ECALL_WB);
    assign wb_data_o    = res_q;
    assign sys_num_o    = num_q;
    assign sys_args_o   = args_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported integer register file with write bypass, pending-write
// scoreboard and a handshaked environment-call channel.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN   = DEFAULT_XLEN,
    parameter  int unsigned NREGS  = DEFAULT_NREGS,
    parameter  int unsigned NREAD  = 3,
    parameter  int unsigned NWRITE = 2,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [XLEN-1:0]         stackptr,
    input  logic [NREAD*AW-1:0]     rd_addr,
    output logic [NREAD*XLEN-1:0]   rd_data,
    input  logic [NWRITE-1:0]       wr_en,
    input  logic [NWRITE*AW-1:0]    wr_addr,
    input  logic [NWRITE*XLEN-1:0]  wr_data,
    input  logic                    alloc_en,
    input  logic [AW-1:0]           alloc_reg,
    output logic [NREGS-1:0]        busy,
    input  logic                    ecall,
    output logic                    ecall_done,
    output logic                    sys_valid,
    input  logic                    sys_ready,
    output logic [XLEN-1:0]         sys_num,
    output logic [NARGS*XLEN-1:0]   sys_args,
    input  logic                    sys_resp_valid,
    input  logic [XLEN-1:0]         sys_resp_data
);

    logic [XLEN-1:0]       regs_q [NREGS];
    logic [XLEN-1:0]       regs_d [NREGS];
    logic [NREGS-1:0]      busy_q, busy_d;
    logic                  wb_en;
    logic [XLEN-1:0]       wb_data;
    logic [XLEN-1:0]       snap_num;
    logic [NARGS*XLEN-1:0] snap_args;

    // Highest-index matching write port wins; index 0 is hard-wired to zero.
    function automatic logic [XLEN-1:0] bypass_read(input logic [AW-1:0] idx);
        logic [XLEN-1:0] v;
        v = regs_q[idx];
        for (int unsigned w = 0; w < NWRITE; w++) begin
            if (wr_en[w] && wr_addr[w*AW +: AW] == idx) v = wr_data[w*XLEN +: XLEN];
        end
        if (idx == AW'(REG_ZERO)) v = '0;
        return v;
    endfunction

    always_comb begin
        rd_data = '0;
        for (int unsigned p = 0; p < NREAD; p++) begin
            rd_data[p*XLEN +: XLEN] = bypass_read(rd_addr[p*AW +: AW]);
        end
    end

    always_comb begin
        snap_num  = bypass_read(AW'(REG_A7));
        snap_args = '0;
        for (int unsigned i = 0; i < NARGS; i++) begin
            snap_args[i*XLEN +: XLEN] = bypass_read(AW'(REG_A0 + i));
        end
    end

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned w = 0; w < NWRITE; w++) begin
            if (wr_en[w] && wr_addr[w*AW +: AW] != AW'(REG_ZERO)) begin
                regs_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
                busy_d[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (wb_en) begin
            regs_d[REG_A0] = wb_data;
            busy_d[REG_A0] = 1'b0;
        end
        // Allocation is applied last so a same-cycle set beats any clear.
        if (alloc_en && alloc_reg != AW'(REG_ZERO)) busy_d[alloc_reg] = 1'b1;
        regs_d[REG_ZERO] = '0;
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == REG_SP) ? stackptr : '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    regfile_ecall_fsm #(
        .XLEN (XLEN)
    ) u_ecall_fsm (
        .clk_i            (clk),
        .rst_ni           (reset),
        .ecall_i          (ecall),
        .sys_ready_i      (sys_ready),
        .sys_resp_valid_i (sys_resp_valid),
        .sys_resp_data_i  (sys_resp_data),
        .snap_num_i       (snap_num),
        .snap_args_i      (snap_args),
        .sys_valid_o      (sys_valid),
        .ecall_done_o     (ecall_done),
        .sys_num_o        (sys_num),
        .sys_args_o       (sys_args),
        .wb_en_o          (wb_en),
        .wb_data_o        (wb_data)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp against an array-based model.
`timescale 1ns/1ps
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int XLEN   = 64;
    localparam int NREGS  = 32;
    localparam int NREAD  = 3;
    localparam int NWRITE = 2;
    localparam int AW     = 5;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [XLEN-1:0]        stackptr;
    logic [NREAD*AW-1:0]    rd_addr;
    logic [NREAD*XLEN-1:0]  rd_data;
    logic [NWRITE-1:0]      wr_en;
    logic [NWRITE*AW-1:0]   wr_addr;
    logic [NWRITE*XLEN-1:0] wr_data;
    logic                   alloc_en;
    logic [AW-1:0]          alloc_reg;
    logic [NREGS-1:0]       busy;
    logic                   ecall;
    logic                   ecall_done;
    logic                   sys_valid;
    logic                   sys_ready;
    logic [XLEN-1:0]        sys_num;
    logic [7*XLEN-1:0]      sys_args;
    logic                   sys_resp_valid;
    logic [XLEN-1:0]        sys_resp_data;

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .NWRITE (NWRITE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stackptr       (stackptr),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .alloc_en       (alloc_en),
        .alloc_reg      (alloc_reg),
        .busy           (busy),
        .ecall          (ecall),
        .ecall_done     (ecall_done),
        .sys_valid      (sys_valid),
        .sys_ready      (sys_ready),
        .sys_num        (sys_num),
        .sys_args       (sys_args),
        .sys_resp_valid (sys_resp_valid),
        .sys_resp_data  (sys_resp_data)
    );

    logic [XLEN-1:0]  mdl [NREGS];
    logic [NREGS-1:0] mbusy;
    bit               wb_expect;
    logic [XLEN-1:0]  wb_val;
    int               total = 0;
    int               bad   = 0;

    task automatic chk(input string tag, input logic [7*XLEN-1:0] got, input logic [7*XLEN-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] model_read(input int idx);
        if (idx == 0) return '0;
        for (int w = NWRITE - 1; w >= 0; w--) begin
            if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == idx) return wr_data[w*XLEN +: XLEN];
        end
        return mdl[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) mdl[i] = '0;
        mdl[REG_SP] = stackptr;
        mbusy = '0;
    endtask

    task automatic model_clock();
        int a;
        for (int w = 0; w < NWRITE; w++) begin
            a = int'(wr_addr[w*AW +: AW]);
            if (wr_en[w] && a != 0) begin
                mdl[a]   = wr_data[w*XLEN +: XLEN];
                mbusy[a] = 1'b0;
            end
        end
        if (wb_expect) begin
            mdl[REG_A0]   = wb_val;
            mbusy[REG_A0] = 1'b0;
        end
        if (alloc_en && alloc_reg != '0) mbusy[alloc_reg] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic set_wr(input int p, input logic en, input int a, input logic [XLEN-1:0] d);
        wr_en[p]              = en;
        wr_addr[p*AW +: AW]   = AW'(a);
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic write_reg(input int a, input logic [XLEN-1:0] d);
        set_wr(0, 1'b1, a, d);
        tick();
        wr_en = '0;
    endtask

    task automatic check_reads(input string tag);
        for (int p = 0; p < NREAD; p++) begin
            chk($sformatf("%s_rd%0d", tag, p), rd_data[p*XLEN +: XLEN],
                model_read(int'(rd_addr[p*AW +: AW])));
        end
        chk({tag, "_busy"}, busy, mbusy);
    endtask

    task automatic do_ecall(input int rdy_dly, input int rsp_dly, input logic [XLEN-1:0] rsp,
                            input bit drop, input bit clash);
        logic [XLEN-1:0]   enum_v;
        logic [7*XLEN-1:0] eargs;
        enum_v = model_read(REG_A7);
        for (int i = 0; i < 7; i++) eargs[i*XLEN +: XLEN] = model_read(REG_A0 + i);
        ecall = 1'b1;
        #1 chk("ec_idle_valid", sys_valid, 0);
        tick();
        for (int k = 0; k < rdy_dly; k++) begin
            sys_resp_valid = 1'b1;
            sys_resp_data  = ~rsp;
            #1;
            chk("ec_req_valid", sys_valid, 1);
            chk("ec_req_num", sys_num, enum_v);
            chk("ec_req_args", sys_args, eargs);
            tick();
        end
        sys_resp_valid = 1'b0;
        sys_ready      = 1'b1;
        #1;
        chk("ec_acc_valid", sys_valid, 1);
        chk("ec_acc_num", sys_num, enum_v);
        chk("ec_acc_args", sys_args, eargs);
        tick();
        sys_ready = 1'b0;
        for (int k = 0; k < rsp_dly; k++) begin
            #1;
            chk("ec_wait_valid", sys_valid, 0);
            chk("ec_wait_done", ecall_done, 0);
            tick();
        end
        sys_resp_valid = 1'b1;
        sys_resp_data  = rsp;
        if (drop) ecall = 1'b0;
        #1 chk("ec_resp_valid", sys_valid, 0);
        tick();
        sys_resp_valid = 1'b0;
        if (clash) set_wr(0, 1'b1, REG_A0, 64'h55);
        wb_expect = 1'b1;
        wb_val    = rsp;
        #1 chk("ec_wb_done", ecall_done, 0);
        tick();
        wb_expect = 1'b0;
        wr_en     = '0;
        set_rd(0, REG_A0);
        #1;
        chk("ec_done", ecall_done, 1);
        chk("ec_a0_result", rd_data[XLEN-1:0], rsp);
        chk("ec_a0_model", rd_data[XLEN-1:0], model_read(REG_A0));
        chk("ec_busy", busy, mbusy);
        if (!drop) begin
            tick();
            #1 chk("ec_done_hold", ecall_done, 1);
            ecall = 1'b0;
            tick();
            #1 chk("ec_done_fall", ecall_done, 0);
        end else begin
            tick();
            #1;
            chk("ec_drop_done", ecall_done, 0);
            chk("ec_drop_valid", sys_valid, 0);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        stackptr       = 64'h8000_0000;
        rd_addr        = '0;
        wr_en          = '0;
        wr_addr        = '0;
        wr_data        = '0;
        alloc_en       = 1'b0;
        alloc_reg      = '0;
        ecall          = 1'b0;
        sys_ready      = 1'b0;
        sys_resp_valid = 1'b0;
        sys_resp_data  = '0;
        wb_expect      = 1'b0;
        wb_val         = '0;
        model_reset();
        @(negedge clk);

        for (int i = 0; i < NREGS; i++) begin
            set_rd(0, i);
            #1 chk($sformatf("rst_reg%0d", i), rd_data[XLEN-1:0], (i == REG_SP) ? 64'h8000_0000 : 64'h0);
            @(negedge clk);
        end
        chk("rst_busy", busy, 0);
        chk("rst_valid", sys_valid, 0);
        chk("rst_done", ecall_done, 0);
        chk("rst_num", sys_num, 0);
        reset = 1'b1;
        tick();

        set_wr(0, 1'b1, 5, 64'h11);
        set_wr(1, 1'b1, 5, 64'h22);
        set_rd(0, 5);
        #1 chk("prio_bypass", rd_data[XLEN-1:0], 64'h22);
        tick();
        wr_en = '0;
        #1 chk("prio_stored", rd_data[XLEN-1:0], 64'h22);
        set_wr(0, 1'b1, 0, 64'hFF);
        set_rd(0, 0);
        #1 chk("zero_bypass", rd_data[XLEN-1:0], 64'h0);
        tick();
        wr_en = '0;
        #1 chk("zero_stored", rd_data[XLEN-1:0], 64'h0);

        alloc_en  = 1'b1;
        alloc_reg = 5'd7;
        tick();
        alloc_en = 1'b0;
        #1 chk("alloc_set", busy[7], 1);
        alloc_en = 1'b1;
        set_wr(0, 1'b1, 7, 64'h77);
        tick();
        alloc_en = 1'b0;
        wr_en    = '0;
        #1 chk("alloc_beats_clear", busy[7], 1);
        write_reg(7, 64'h78);
        #1 chk("write_clears", busy[7], 0);
        alloc_en  = 1'b1;
        alloc_reg = 5'd0;
        tick();
        alloc_en = 1'b0;
        #1 chk("alloc_zero", busy[0], 0);

        for (int n = 0; n < 400; n++) begin
            for (int w = 0; w < NWRITE; w++) begin
                set_wr(w, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31)),
                       {$urandom, $urandom});
            end
            for (int p = 0; p < NREAD; p++) begin
                set_rd(p, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31)));
            end
            alloc_en  = 1'($urandom_range(0, 1));
            alloc_reg = AW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 31));
            #1 check_reads("rnd");
            tick();
        end
        wr_en    = '0;
        alloc_en = 1'b0;

        write_reg(REG_A7, 64'd93);
        write_reg(REG_A0, 64'd1);
        alloc_en  = 1'b1;
        alloc_reg = AW'(REG_A0);
        tick();
        alloc_en = 1'b0;
        #1 chk("a0_busy_pre", busy[REG_A0], 1);
        do_ecall(3, 0, 64'h2A, 1'b0, 1'b0);
        do_ecall(1, 2, 64'hDEAD_BEEF_0000_0042, 1'b0, 1'b1);

        for (int n = 0; n < 6; n++) begin
            for (int r = REG_A0; r <= REG_A7; r++) write_reg(r, {$urandom, $urandom});
            do_ecall(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), {$urandom, $urandom},
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        write_reg(REG_A0, 64'h1234);
        ecall = 1'b1;
        tick();
        sys_ready = 1'b1;
        tick();
        sys_ready = 1'b0;
        #1 chk("abort_in_wait", sys_valid, 0);
        stackptr = 64'hCAFE_0000_0000_1000;
        reset    = 1'b0;
        model_reset();
        set_rd(0, REG_SP);
        set_rd(1, REG_A0);
        #1;
        chk("abort_valid", sys_valid, 0);
        chk("abort_done", ecall_done, 0);
        chk("abort_num", sys_num, 0);
        chk("abort_args", sys_args, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sp", rd_data[XLEN-1:0], 64'hCAFE_0000_0000_1000);
        chk("abort_a0", rd_data[2*XLEN-1:XLEN], 64'h0);
        @(negedge clk);
        reset = 1'b1;
        ecall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sys_resp_valid = 1'b1;
            sys_resp_data  = 64'hBAD;
            tick();
            #1;
            chk("late_resp_done", ecall_done, 0);
            chk("late_resp_valid", sys_valid, 0);
            chk("late_resp_a0", rd_data[2*XLEN-1:XLEN], model_read(REG_A0));
        end
        sys_resp_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-ported integer register file with write-port priority, same-cycle write-to-read bypass, a per-register pending-write scoreboard and a handshaked environment-call channel that replaces in-simulator call handling with an explicit request/acknowledge interface. It sits between decode/issue (read ports, scoreboard allocation) and writeback (write ports), and fronts the system-call responder.

## Interface
- XLEN, 64, register width in bits
- NREGS, 32, number of architectural registers (power of two, >= 32)
- NREAD, 3, read ports (two operand ports plus one branch-predictor port in the default build)
- NWRITE, 2, write ports
- AW, $clog2(NREGS), register index width (derived, not overridden)

- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low; resets all state immediately on assertion
- stackptr  in  XLEN  value loaded into register 2 during reset; must be stable while reset is low
- rd_addr  in  NREAD×AW  read indices
- rd_data  out  NREAD×XLEN  read data (combinational)
- wr_en  in  NWRITE  per-port write enable
- wr_addr  in  NWRITE×AW  write indices
- wr_data  in  NWRITE×XLEN  write data
- alloc_en  in  1  mark alloc_reg as pending-write
- alloc_reg  in  AW  register being allocated
- busy  out  NREGS  scoreboard bits, bit i = register i has a pending write
- ecall  in  1  environment-call request, held high until ecall_done seen
- ecall_done  out  1  call complete, result written
- sys_valid  out  1  call presented to responder
- sys_ready  in  1  responder accepts call
- sys_num  out  XLEN  snapshot of register 17
- sys_args  out  7×XLEN  snapshot of registers 10..16
- sys_resp_valid  in  1  responder result valid
- sys_resp_data  in  XLEN  result, written to register 10

## Operation
- Reads: rd_data[p] = data of highest-index write port with wr_en and wr_addr == rd_addr[p] and wr_addr != 0; else stored value. Index 0 always reads 0.
- Writes: writes to index 0 discarded. Two ports on same index in one cycle: higher port index wins.
- Scoreboard: alloc_en sets busy[alloc_reg]; any effective wr_en clears busy[wr_addr]. Set and clear same register same cycle: set wins. busy[0] constant 0; alloc of 0 ignored.
- Ecall FSM states: IDLE, REQ, WAIT, WB, DONE.
  - IDLE: ecall high -> capture sys_num/sys_args from registers (bypassed values, same as read ports) -> REQ.
  - REQ: sys_valid=1, snapshot held stable; sys_ready high -> WAIT (sys_valid low next cycle).
  - WAIT: sys_resp_valid high -> latch sys_resp_data -> WB. Responses outside WAIT ignored.
  - WB: write latched result to register 10, clear busy[10] -> DONE. Writeback beats any write port targeting 10 that cycle.
  - DONE: ecall_done=1; ecall low -> IDLE. ecall dropped in REQ/WAIT: transaction still completes through WB, then DONE falls straight to IDLE.
- Reset values: all registers 0 except register 2 = stackptr; busy all 0; FSM IDLE; sys_valid 0, ecall_done 0, sys_num/sys_args 0.

## Timing
- Read latency 0 (combinational, bypass included); write visible in storage next edge.
- Ecall minimum: ecall rising edge cycle N -> sys_valid at N+1 -> (sys_ready same cycle) WAIT at N+2 -> response at N+2 -> WB N+3 -> ecall_done N+4; register 10 readable with result at N+4.
- sys_valid, sys_num, sys_args never change while sys_valid high and sys_ready low.
- Reset asserted mid-transaction: FSM to IDLE, outputs to reset values immediately; responder must tolerate an abandoned request.

## Structure
- Shared package regfile_pkg: ecall state enum, register index constants (ZERO=0, SP=2, A0=10, A7=17), default XLEN/NREGS.
- One sub-module: regfile_ecall_fsm (FSM, snapshot and result latch); storage, bypass and scoreboard stay in regfile_mp.

## Test plan
- Reset low with stackptr=0x8000_0000: every register reads 0, register 2 reads 0x8000_0000, busy=0, sys_valid=0.
- Port0 writes 0x11 and port1 writes 0x22 to reg 5 same cycle, rd_addr[0]=5 -> reads 0x22 that cycle and after; write 0xFF to reg 0 -> reads 0.
- alloc reg 7 -> busy[7]=1; next cycle alloc 7 and write 7 together -> busy[7] stays 1; write alone -> 0.
- Reg17=93, reg10=1; ecall with sys_ready held low 3 cycles -> sys_valid, sys_num=93, sys_args[0]=1 stable; ready, resp 0x2A -> reg10=0x2A, ecall_done high until ecall low.
- Same-cycle port write 0x55 to reg 10 during WB -> reg 10 = response value.
- Reset pulled low while in WAIT -> sys_valid/ecall_done 0, FSM IDLE; later sys_resp_valid ignored.
